// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction-type encodings and decoded-field payload.
package decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned ITYPE_W = 3;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    typedef enum logic [ITYPE_W-1:0] {
        IT_R   = 3'd0,
        IT_I   = 3'd1,
        IT_S   = 3'd2,
        IT_B   = 3'd3,
        IT_U   = 3'd4,
        IT_J   = 3'd5,
        IT_ILL = 3'd7
    } itype_e;

    // Decoded fields held in the pipeline registers (imm and pc kept separately
    // because their widths are parameters of the decoder).
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  func3;
        logic [F7_W-1:0]  func7;
        itype_e           itype;
        logic             illegal;
    } dec_fields_t;

    // Instruction format from the opcode; anything unrecognised (including
    // opcodes whose low two bits are not 2'b11) is illegal.
    function automatic itype_e opcode_itype(input logic [OPC_W-1:0] opc);
        itype_e t;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = IT_I;
            OPC_STORE:                      t = IT_S;
            OPC_BRANCH:                     t = IT_B;
            OPC_LUI, OPC_AUIPC:             t = IT_U;
            OPC_JAL:                        t = IT_J;
            OPC_OP:                         t = IT_R;
            default:                        t = IT_ILL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pipelined_decode_if.sv
// Upstream/downstream handshake and decoded-field bus of the decoder.
interface pipelined_decode_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic [2:0]      itype;
    logic            illegal;

    // Instruction source / result sink side
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc,
        input  rs1, rs2, rd, opcode, func3, func7, imm, itype, illegal
    );

    // Decoder side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc,
        output rs1, rs2, rd, opcode, func3, func7, imm, itype, illegal
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator for all base-ISA formats.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          SIGN_EXT = 1'b1
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm
);

    logic ext;

    // Fill bit for everything above the format's top bit.
    assign ext = SIGN_EXT ? instr[31] : 1'b0;

    // Assemble the immediate for the decoded format; R and illegal give zero.
    always_comb begin
        imm = '0;
        case (opcode_itype(instr[6:0]))
            IT_I:    imm = {{(XLEN-12){ext}}, instr[31:20]};
            IT_S:    imm = {{(XLEN-12){ext}}, instr[31:25], instr[11:7]};
            IT_B:    imm = {{(XLEN-13){ext}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IT_U:    imm = {{(XLEN-32){ext}}, instr[31:12], 12'h000};
            IT_J:    imm = {{(XLEN-21){ext}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_decode.sv
// Single-stage instruction decoder with output register plus one skid entry.
module pipelined_decode
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_W     = 32,
    parameter bit          SIGN_EXT = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    pipelined_decode_if.slave  bus
);

    itype_e          in_itype;
    dec_fields_t     in_fields;
    logic [XLEN-1:0] in_imm;

    logic            out_valid_q;
    dec_fields_t     out_fields_q;
    logic [XLEN-1:0] out_imm_q;
    logic [PC_W-1:0] out_pc_q;

    logic            skid_valid_q;
    dec_fields_t     skid_fields_q;
    logic [XLEN-1:0] skid_imm_q;
    logic [PC_W-1:0] skid_pc_q;

    logic            in_xfer;
    logic            out_drain;
    logic            out_valid_d;
    logic            skid_valid_d;
    logic            load_out_in;
    logic            load_out_skid;
    logic            load_skid;

    assign in_itype = opcode_itype(bus.in_instr[6:0]);

    // Decode the incoming instruction so only decoded fields are ever stored.
    always_comb begin
        in_fields         = '0;
        in_fields.rs1     = bus.in_instr[19:15];
        in_fields.rs2     = bus.in_instr[24:20];
        in_fields.rd      = bus.in_instr[11:7];
        in_fields.opcode  = bus.in_instr[6:0];
        in_fields.func3   = bus.in_instr[14:12];
        in_fields.func7   = bus.in_instr[31:25];
        in_fields.itype   = in_itype;
        in_fields.illegal = (in_itype == IT_ILL);
    end

    imm_gen #(
        .XLEN     (XLEN),
        .SIGN_EXT (SIGN_EXT)
    ) u_imm_gen (
        .instr (bus.in_instr),
        .imm   (in_imm)
    );

    assign in_xfer   = bus.in_valid && !skid_valid_q;
    assign out_drain = out_valid_q && bus.out_ready;

    // Occupancy update: skid refills the output first, else the new instruction goes straight in.
    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_drain) begin
            if (skid_valid_q) begin
                load_out_skid = 1'b1;
                out_valid_d   = 1'b1;
                skid_valid_d  = 1'b0;
            end else if (in_xfer) begin
                load_out_in = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    // Pipeline registers; reset wins over flush and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_fields_q  <= '0;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_fields_q <= '0;
            skid_imm_q    <= '0;
            skid_pc_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (load_out_skid) begin
                out_fields_q <= skid_fields_q;
                out_imm_q    <= skid_imm_q;
                out_pc_q     <= skid_pc_q;
            end else if (load_out_in) begin
                out_fields_q <= in_fields;
                out_imm_q    <= in_imm;
                out_pc_q     <= bus.in_pc;
            end
            if (load_skid) begin
                skid_fields_q <= in_fields;
                skid_imm_q    <= in_imm;
                skid_pc_q     <= bus.in_pc;
            end
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.rs1       = out_fields_q.rs1;
    assign bus.rs2       = out_fields_q.rs2;
    assign bus.rd        = out_fields_q.rd;
    assign bus.opcode    = out_fields_q.opcode;
    assign bus.func3     = out_fields_q.func3;
    assign bus.func7     = out_fields_q.func7;
    assign bus.imm       = out_imm_q;
    assign bus.itype     = out_fields_q.itype;
    assign bus.illegal   = out_fields_q.illegal;

endmodule

// File: tb/tb_pipelined_decode.sv
// Bench for pipelined_decode: queue model of the two-entry pipe plus RV32 decode rules.
module tb_pipelined_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    always #5 clock = ~clock;

    pipelined_decode_if #(.XLEN(32), .PC_W(32)) bus_s ();
    pipelined_decode_if #(.XLEN(32), .PC_W(32)) bus_z ();
    pipelined_decode_if #(.XLEN(64), .PC_W(32)) bus_w ();

    assign bus_s.in_valid = in_valid;
    assign bus_s.in_instr = in_instr;
    assign bus_s.in_pc = in_pc;
    assign bus_s.out_ready = out_ready;
    assign bus_z.in_valid = in_valid;
    assign bus_z.in_instr = in_instr;
    assign bus_z.in_pc = in_pc;
    assign bus_z.out_ready = out_ready;
    assign bus_w.in_valid = in_valid;
    assign bus_w.in_instr = in_instr;
    assign bus_w.in_pc = in_pc;
    assign bus_w.out_ready = out_ready;

    pipelined_decode #(.XLEN(32), .PC_W(32), .SIGN_EXT(1'b1)) dut_s (
        .clock (clock), .reset (reset), .flush (flush), .bus (bus_s));
    pipelined_decode #(.XLEN(32), .PC_W(32), .SIGN_EXT(1'b0)) dut_z (
        .clock (clock), .reset (reset), .flush (flush), .bus (bus_z));
    pipelined_decode #(.XLEN(64), .PC_W(32), .SIGN_EXT(1'b1)) dut_w (
        .clock (clock), .reset (reset), .flush (flush), .bus (bus_w));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    txn_t q[$];
    bit   post_reset;
    bit   last_acc;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [2:0] ref_itype(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67: return 3'd1;
            7'h23:               return 3'd2;
            7'h63:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            7'h6F:               return 3'd5;
            7'h33:               return 3'd0;
            default:             return 3'd7;
        endcase
    endfunction

    // Immediate as a signed number, then truncated to the datapath width.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xlen, input bit se);
        longint      v;
        logic [11:0] f12;
        logic [11:0] b12;
        logic [19:0] f20;
        logic [19:0] j20;
        v = 0;
        case (ref_itype(i[6:0]))
            3'd1: begin
                f12 = i[31:20];
                v = longint'(f12);
                if (se && i[31]) v = v - 64'sd4096;
            end
            3'd2: begin
                f12 = {i[31:25], i[11:7]};
                v = longint'(f12);
                if (se && i[31]) v = v - 64'sd4096;
            end
            3'd3: begin
                b12 = {i[31], i[7], i[30:25], i[11:8]};
                v = longint'(b12) * 2;
                if (se && i[31]) v = v - 64'sd8192;
            end
            3'd4: begin
                f20 = i[31:12];
                v = longint'(f20) * 4096;
                if (se && i[31]) v = v - 64'sd4294967296;
            end
            3'd5: begin
                j20 = {i[31], i[19:12], i[20], i[30:21]};
                v = longint'(j20) * 2;
                if (se && i[31]) v = v - 64'sd2097152;
            end
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'sh0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input int xlen, input bit se,
                             input logic ov, input logic ir,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [63:0] imm, input logic [2:0] it, input logic ill,
                             input logic [31:0] pc);
        txn_t        t;
        logic [2:0]  eit;
        chk({tag, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
        chk({tag, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
        if (q.size() > 0) begin
            t   = q[0];
            eit = ref_itype(t.instr[6:0]);
            chk({tag, ".rs1"}, 64'(rs1), 64'(t.instr[19:15]));
            chk({tag, ".rs2"}, 64'(rs2), 64'(t.instr[24:20]));
            chk({tag, ".rd"}, 64'(rd), 64'(t.instr[11:7]));
            chk({tag, ".opcode"}, 64'(opc), 64'(t.instr[6:0]));
            chk({tag, ".func3"}, 64'(f3), 64'(t.instr[14:12]));
            chk({tag, ".func7"}, 64'(f7), 64'(t.instr[31:25]));
            chk({tag, ".itype"}, 64'(it), 64'(eit));
            chk({tag, ".illegal"}, 64'(ill), 64'(eit == 3'd7));
            chk({tag, ".imm"}, imm, (eit == 3'd7) ? 64'h0 : ref_imm(t.instr, xlen, se));
            chk({tag, ".out_pc"}, 64'(pc), 64'(t.pc));
        end else if (post_reset) begin
            chk({tag, ".rst_fields"}, 64'({rs1, rs2, rd, opc, f3, f7, it, ill}), 64'h0);
            chk({tag, ".rst_imm"}, imm, 64'h0);
            chk({tag, ".rst_pc"}, 64'(pc), 64'h0);
        end
    endtask

    task automatic compare();
        check_dut("s", 32, 1'b1, bus_s.out_valid, bus_s.in_ready, bus_s.rs1, bus_s.rs2, bus_s.rd,
                  bus_s.opcode, bus_s.func3, bus_s.func7, 64'(bus_s.imm), bus_s.itype,
                  bus_s.illegal, bus_s.out_pc);
        check_dut("z", 32, 1'b0, bus_z.out_valid, bus_z.in_ready, bus_z.rs1, bus_z.rs2, bus_z.rd,
                  bus_z.opcode, bus_z.func3, bus_z.func7, 64'(bus_z.imm), bus_z.itype,
                  bus_z.illegal, bus_z.out_pc);
        check_dut("w", 64, 1'b1, bus_w.out_valid, bus_w.in_ready, bus_w.rs1, bus_w.rs2, bus_w.rd,
                  bus_w.opcode, bus_w.func3, bus_w.func7, bus_w.imm, bus_w.itype,
                  bus_w.illegal, bus_w.out_pc);
    endtask

    // One clock: decide the model's transfers from pre-edge inputs, clock, then compare.
    task automatic step();
        bit   acc;
        bit   drn;
        txn_t t;
        acc = 1'b0;
        drn = 1'b0;
        t.instr = in_instr;
        t.pc    = in_pc;
        if (!reset && !flush) begin
            drn = (q.size() > 0) && out_ready;
            acc = in_valid && (q.size() < 2);
        end
        @(posedge clock);
        #1;
        if (reset) begin
            q.delete();
            post_reset = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(t);
                post_reset = 1'b0;
            end
        end
        last_acc = acc;
        compare();
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    logic [31:0] mix [12] = '{
        32'h00112623, 32'hFF5FF0EF, 32'h002081B3, 32'h00001517,
        32'hFFC12083, 32'h000080E7, 32'h00000091, 32'h008000EF,
        32'h0000007F, 32'hFFF00093, 32'h800000B7, 32'hFE000EE3
    };

    initial begin
        int idx;
        logic [15:0] rdy_pat;
        logic [15:0] vld_pat;
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        post_reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("lit.reset.out_valid", 64'(bus_s.out_valid), 64'h0);
        chk("lit.reset.in_ready", 64'(bus_s.in_ready), 64'h1);

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("lit.addi.out_valid", 64'(bus_s.out_valid), 64'h1);
        chk("lit.addi.rd", 64'(bus_s.rd), 64'h1);
        chk("lit.addi.itype", 64'(bus_s.itype), 64'h1);
        chk("lit.addi.imm_sext", 64'(bus_s.imm), 64'hFFFF_FFFF);
        chk("lit.addi.imm_zext", 64'(bus_z.imm), 64'h0000_0FFF);
        step();

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h104);
        step();
        chk("lit.beq.itype", 64'(bus_s.itype), 64'h3);
        chk("lit.beq.imm", 64'(bus_s.imm), 64'hFFFF_FFFC);

        // lui x1,0x80000 on the 64-bit decoder
        drive(1'b1, 32'h800000B7, 32'h108);
        step();
        chk("lit.lui64.imm", bus_w.imm, 64'hFFFF_FFFF_8000_0000);
        chk("lit.lui64.itype", 64'(bus_w.itype), 64'h4);

        // all-zero word is illegal
        drive(1'b1, 32'h00000000, 32'h10C);
        step();
        chk("lit.zero.illegal", 64'(bus_s.illegal), 64'h1);
        chk("lit.zero.itype", 64'(bus_s.itype), 64'h7);
        chk("lit.zero.imm", 64'(bus_s.imm), 64'h0);

        // back-to-back stream, output always ready
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, mix[i], 32'h200 + 32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        step();

        // stall: A held, B in skid, C waits
        out_ready = 1'b0;
        drive(1'b1, 32'h00500113, 32'hA00);
        step();
        drive(1'b1, 32'h00208233, 32'hB00);
        step();
        drive(1'b1, 32'h40110133, 32'hC00);
        step();
        chk("lit.stall.in_ready", 64'(bus_s.in_ready), 64'h0);
        chk("lit.stall.out_pc", 64'(bus_s.out_pc), 64'hA00);
        out_ready = 1'b1;
        step();
        chk("lit.drain.pc_b", 64'(bus_s.out_pc), 64'hB00);
        step();
        chk("lit.drain.pc_c", 64'(bus_s.out_pc), 64'hC00);
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();

        // flush with both entries full
        out_ready = 1'b0;
        drive(1'b1, 32'h00112623, 32'hD00);
        step();
        drive(1'b1, 32'h008000EF, 32'hE00);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'hF00);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("lit.flush.out_valid", 64'(bus_s.out_valid), 64'h0);
        chk("lit.flush.in_ready", 64'(bus_s.in_ready), 64'h1);
        step();

        // flush while an input transfer is taking place: it is discarded
        out_ready = 1'b0;
        drive(1'b1, 32'h00001517, 32'h1000);
        step();
        flush = 1'b1;
        drive(1'b1, 32'hFE000EE3, 32'h1004);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        chk("lit.flush2.out_valid", 64'(bus_s.out_valid), 64'h0);

        // irregular ready/valid patterns
        idx = 0;
        rdy_pat = 16'b1011_0010_1110_0101;
        vld_pat = 16'b1101_1110_0111_1011;
        for (int c = 0; c < 32; c++) begin
            out_ready = rdy_pat[c % 16];
            drive(vld_pat[(c * 3) % 16], mix[idx % 12], 32'h3000 + 32'(idx * 4));
            step();
            if (last_acc) idx++;
        end
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        step();

        // reset mid-stream with both entries full and input valid
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC12083, 32'h4000);
        step();
        drive(1'b1, 32'h002081B3, 32'h4004);
        step();
        reset = 1'b1;
        drive(1'b1, 32'h00500113, 32'h4008);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        chk("lit.mrst.out_valid", 64'(bus_s.out_valid), 64'h0);
        chk("lit.mrst.imm", 64'(bus_s.imm), 64'h0);
        chk("lit.mrst.rd", 64'(bus_s.rd), 64'h0);
        chk("lit.mrst.in_ready", 64'(bus_s.in_ready), 64'h1);
        for (int c = 0; c < 4; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_decode.md
PIPELINED_DECODE -- requirements
Module: pipelined_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate/datapath width (32 or 64 only).
REQ-002 SHALL have parameter PC_W, default 32, PC passthrough width.
REQ-003 SHALL have parameter SIGN_EXT, default 1: 1 sign-extends immediates from instr[31]; 0 zero-extends (legacy behaviour).
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discards all held and incoming instructions.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input PC_W  upstream handshake.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_pc output PC_W  downstream handshake.
REQ-009 SHALL have outputs rs1 5, rs2 5, rd 5, opcode 7, func3 3, func7 7, imm XLEN  decoded fields.
REQ-010 SHALL have outputs itype 3 (R=0, I=1, S=2, B=3, U=4, J=5, ILL=7) and illegal 1.

Function
REQ-011 SHALL decode combinationally at input; registered storage holds decoded fields, never raw instructions.
REQ-012 SHALL transfer on in_valid&&in_ready; accepted instruction appears on outputs next cycle if output register free or draining (latency 1).
REQ-013 SHALL hold all outputs stable while out_valid&&!out_ready.
REQ-014 SHALL contain one output register plus one skid entry; in_ready = !skid_valid.
REQ-015 SHALL capture an accepted instruction into skid when output is stalled; skid moves to output on the cycle output drains; order strictly FIFO.
REQ-016 SHALL, when output drains with skid empty and input transfers same cycle, load the new instruction directly to output.
REQ-017 SHALL field-extract rs1=[19:15], rs2=[24:20], rd=[11:7], func3=[14:12], func7=[31:25], opcode=[6:0] for every instruction.
REQ-018 SHALL produce imm per opcode: 0010011/0000011/1100111 I; 0100011 S; 1100011 B (bit0=0); 0110111/0010111 U (low 12 zero); 1101111 J (bit0=0); 0110011 R imm=0.
REQ-019 SHALL fill imm bits above the format's MSB with instr[31] if SIGN_EXT=1, else zero; U-type bits [XLEN-1:32] follow the same rule.
REQ-020 SHALL flag any other opcode, or opcode[1:0]!=2'b11, as illegal=1, itype=ILL, imm=0; illegal instructions still flow through the pipeline.
REQ-021 SHALL on flush clear out_valid and skid_valid next cycle; a transfer in the flush cycle is consumed and discarded; flush overrides out_ready.

Reset
REQ-022 SHALL on reset clear out_valid, skid_valid, and all output fields (imm, rs1, rs2, rd, opcode, func3, func7, itype, illegal, out_pc) to 0.
REQ-023 SHALL ignore in_valid in any cycle reset is high; reset mid-stream drops all held instructions; in_ready=1 first cycle after reset.
REQ-024 SHALL give reset priority over flush and handshake.

Structure
REQ-025 SHALL place opcode constants and itype encodings in shared package decode_pkg.
REQ-026 SHALL implement immediate generation in combinational sub-module imm_gen (parameters XLEN, SIGN_EXT).
REQ-027 SHALL avoid latches; every imm bit assigned on every path.

Verification
REQ-028 SHALL test 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, rd=1, itype=1, imm=0xFFFFFFFF; with SIGN_EXT=0 imm=0x00000FFF.
REQ-029 SHALL test 0xFE000EE3 (beq x0,x0,-4) -> itype=3, imm=0xFFFFFFFC.
REQ-030 SHALL test XLEN=64, 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, itype=4.
REQ-031 SHALL test out_ready=0, send A,B -> A held, B in skid, in_ready=0, C stalled; out_ready=1 -> outputs A,B,C in order, no loss/duplicate.
REQ-032 SHALL test flush with output and skid full -> out_valid=0 and in_ready=1 next cycle; 0x00000000 -> illegal=1, itype=7, imm=0.
REQ-033 SHALL test reset asserted mid-stream with in_valid=1 -> all outputs 0 next cycle, no instruction emitted afterwards.
